// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, status codes, register and flag encodings.
package y86_pkg;

  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Flag vector layout is {OF,SF,ZF}
  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam logic [2:0] CC_RESET = 3'b001;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_ERR  = 2'd2
  } proc_state_t;

  // Status latched when a non-AOK instruction reaches writeback.
  function automatic logic [2:0] fault_stat(input logic [2:0] s);
    case (s)
      STAT_HLT, STAT_ADR, STAT_INS: fault_stat = s;
      default:                      fault_stat = STAT_INS;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Register file, 15 x XLEN, two write ports (M beats E on same index); reads combinational.
// No backpressure; writes land on the next rising edge, index RNONE reads zero.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_e,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic            we_m,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m && dst_m == 4'(i))      regs[i] <= val_m;
        else if (we_e && dst_e == 4'(i)) regs[i] <= val_e;
      end
    end
  end

  assign rd_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/writeback_state.sv
// SEQ writeback: register file, CC register, status FSM, retire counter; reads are combinational.
// No backpressure; a commit lands on the next edge. WB_BYPASS_EN forwards same-cycle commit data to reads.
module writeback_state
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [2:0]       stat_in,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [XLEN-1:0]  valE,
  input  logic [XLEN-1:0]  valM,
  input  logic [2:0]       cc_out,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [XLEN-1:0]  valA_rd,
  output logic [XLEN-1:0]  valB_rd,
  output logic [2:0]       cc_in,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  proc_state_t      state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [2:0]       cc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             commit;
  logic             we_e, we_m;
  logic [XLEN-1:0]  rf_a, rf_b;

  assign commit = wb_valid && (state_q == S_RUN) && (stat_in == STAT_AOK);
  // A cmov whose condition failed still retires, it just writes nothing.
  assign we_e   = commit && (dstE != RNONE) && ((icode != ICODE_CMOVXX) || cnd);
  assign we_m   = commit && (dstM != RNONE);

  y86_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we_e  (we_e),
    .dst_e (dstE),
    .val_e (valE),
    .we_m  (we_m),
    .dst_m (dstM),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .rd_a  (rf_a),
    .rd_b  (rf_b)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (state_q == S_RUN && wb_valid && stat_in != STAT_AOK) begin
      stat_d  = fault_stat(stat_in);
      state_d = (stat_in == STAT_HLT) ? S_HALT : S_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      stat_q  <= STAT_AOK;
      cc_q    <= CC_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (commit && icode == ICODE_OPQ) cc_q <= cc_out;
      if (commit) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    valA_rd = rf_a;
    if (we_m && dstM == srcA)      valA_rd = valM;
    else if (we_e && dstE == srcA) valA_rd = valE;
    valB_rd = rf_b;
    if (we_m && dstM == srcB)      valB_rd = valM;
    else if (we_e && dstE == srcB) valB_rd = valE;
  end
`else
  assign valA_rd = rf_a;
  assign valB_rd = rf_b;
`endif

  assign cc_in      = cc_q;
  assign stat       = stat_q;
  assign halted     = (state_q != S_RUN);
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_state.sv
// Bench for writeback_state: directed vector table, hand sequences, then random run against a model.
module tb_writeback_state;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid, cnd;
  logic [3:0]  icode, dstE, dstM, srcA, srcB;
  logic [2:0]  stat_in, cc_out;
  logic [63:0] valE, valM;
  logic [63:0] valA_rd, valB_rd;
  logic [2:0]  cc_in, stat;
  logic        halted;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_state dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .cnd(cnd),
    .stat_in(stat_in), .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
    .cc_out(cc_out), .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd), .valB_rd(valB_rd),
    .cc_in(cc_in), .stat(stat), .halted(halted), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        v; logic [3:0] ic; logic c; logic [2:0] st;
    logic [3:0]  de, dm; logic [63:0] ve, vm; logic [2:0] cco;
    logic [3:0]  sa, sb;
    logic [63:0] ea, eb; logic [2:0] ecc, est; logic eh; logic [31:0] ecnt;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  // Reference model state
  logic [63:0] m_reg [15];
  logic [2:0]  m_cc, m_stat;
  logic        m_run;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 0; icode = 0; cnd = 0; stat_in = 3'd1; dstE = 4'hF; dstM = 4'hF;
    valE = 0; valM = 0; cc_out = 0; srcA = 0; srcB = 4'hF;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = 0;
    m_cc = 3'b001; m_stat = 3'd1; m_run = 1; m_cnt = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    chk({tag, " rst valA"}, valA_rd, 0);
    chk({tag, " rst valB"}, valB_rd, 0);
    chk({tag, " rst cc"}, 64'(cc_in), 1);
    chk({tag, " rst stat"}, 64'(stat), 1);
    chk({tag, " rst halted"}, 64'(halted), 0);
    chk({tag, " rst cnt"}, 64'(retire_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] ic, input logic c, input logic [2:0] st,
                              input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve,
                              input logic [63:0] vm, input logic [2:0] cco, input logic [3:0] sa,
                              input logic [3:0] sb, input logic [63:0] ea, input logic [63:0] eb,
                              input logic [2:0] ecc, input logic [2:0] est, input logic eh,
                              input logic [31:0] ecnt);
    vec_t t;
    t.v = v; t.ic = ic; t.c = c; t.st = st; t.de = de; t.dm = dm; t.ve = ve; t.vm = vm;
    t.cco = cco; t.sa = sa; t.sb = sb; t.ea = ea; t.eb = eb; t.ecc = ecc; t.est = est;
    t.eh = eh; t.ecnt = ecnt;
    return t;
  endfunction

  // Expected read: zero for RNONE, forwarded commit data when bypass is built in, else stored.
  function automatic logic [63:0] exp_rd(input logic [3:0] s);
    logic c;
    c = wb_valid && m_run && (stat_in == 3'd1);
    if (s == 4'hF) return 0;
    if (BYP && c) begin
      if (dstM == s) return valM;
      if (dstE == s && (icode != 4'h2 || cnd)) return valE;
    end
    return m_reg[s];
  endfunction

  task automatic model_step();
    if (wb_valid && m_run) begin
      if (stat_in == 3'd1) begin
        if (dstE != 4'hF && (icode != 4'h2 || cnd)) m_reg[dstE] = valE;
        if (dstM != 4'hF) m_reg[dstM] = valM;
        if (icode == 4'h6) m_cc = cc_out;
        m_cnt = m_cnt + 1;
      end else begin
        m_run = 0;
        m_stat = (stat_in >= 3'd2 && stat_in <= 3'd4) ? stat_in : 3'd4;
      end
    end
  endtask

  initial begin
    idle_inputs();
    // v, ic, c, st, dE, dM, vE, vM, cco, sA, sB | eA, eB, ecc, est, eh, ecnt
    tv[0]  = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 0, 15, 0,    0,    3'b001, 1, 0, 0);
    tv[1]  = mk(1, 3, 0, 1, 2,  15, 'h55, 0,    0, 0, 1,  0,    0,    3'b001, 1, 0, 0);
    tv[2]  = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 2, 3,  'h55, 0,    3'b001, 1, 0, 1);
    tv[3]  = mk(1, 2, 0, 1, 3,  15, 7,    0,    0, 2, 15, 'h55, 0,    3'b001, 1, 0, 1);
    tv[4]  = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 3, 2,  0,    'h55, 3'b001, 1, 0, 2);
    tv[5]  = mk(1, 2, 1, 1, 3,  15, 7,    0,    0, 0, 15, 0,    0,    3'b001, 1, 0, 2);
    tv[6]  = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 3, 2,  7,    'h55, 3'b001, 1, 0, 3);
    tv[7]  = mk(1, 5, 0, 1, 4,  4,  'h10, 'h20, 0, 3, 2,  7,    'h55, 3'b001, 1, 0, 3);
    tv[8]  = mk(1, 6, 0, 1, 15, 15, 0,    0,    6, 4, 15, 'h20, 0,    3'b001, 1, 0, 4);
    tv[9]  = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 4, 15, 'h20, 0,    3'b110, 1, 0, 5);
    tv[10] = mk(0, 6, 0, 1, 15, 15, 0,    0,    3, 4, 15, 'h20, 0,    3'b110, 1, 0, 5);
    tv[11] = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 4, 15, 'h20, 0,    3'b110, 1, 0, 5);
    tv[12] = mk(1, 0, 0, 2, 1,  15, 99,   0,    0, 1, 15, 0,    0,    3'b110, 1, 0, 5);
    tv[13] = mk(1, 6, 0, 1, 1,  15, 'h77, 0,    1, 1, 15, 0,    0,    3'b110, 2, 1, 5);
    tv[14] = mk(0, 0, 0, 1, 15, 15, 0,    0,    0, 1, 15, 0,    0,    3'b110, 2, 1, 5);

    do_reset("init");
    for (int i = 0; i < NV; i++) begin
      wb_valid = tv[i].v; icode = tv[i].ic; cnd = tv[i].c; stat_in = tv[i].st;
      dstE = tv[i].de; dstM = tv[i].dm; valE = tv[i].ve; valM = tv[i].vm;
      cc_out = tv[i].cco; srcA = tv[i].sa; srcB = tv[i].sb;
      @(negedge clk);
      chk($sformatf("v%0d valA", i), valA_rd, tv[i].ea);
      chk($sformatf("v%0d valB", i), valB_rd, tv[i].eb);
      chk($sformatf("v%0d cc", i), 64'(cc_in), 64'(tv[i].ecc));
      chk($sformatf("v%0d stat", i), 64'(stat), 64'(tv[i].est));
      chk($sformatf("v%0d halted", i), 64'(halted), 64'(tv[i].eh));
      chk($sformatf("v%0d cnt", i), 64'(retire_cnt), 64'(tv[i].ecnt));
      @(posedge clk); #1;
    end

    // Same-cycle read of a register being written by dstM
    do_reset("byp");
    wb_valid = 1; icode = 4'h5; dstM = 4'h5; valM = 64'hAB; srcA = 4'h5; srcB = 4'h5;
    @(negedge clk);
    chk("byp sameB", valB_rd, BYP ? 64'hAB : 64'h0);
    chk("byp sameA", valA_rd, BYP ? 64'hAB : 64'h0);
    @(posedge clk); #1;
    wb_valid = 0;
    @(negedge clk);
    chk("byp nextB", valB_rd, 64'hAB);

    // Reset landing before the commit edge discards that commit
    @(posedge clk); #1;
    wb_valid = 1; icode = 4'h3; dstE = 4'h6; valE = 64'h66; srcA = 4'h6; dstM = 4'hF;
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    idle_inputs();
    srcA = 4'h6;
    @(negedge clk);
    chk("midrst reg6", valA_rd, 0);
    chk("midrst cnt", 64'(retire_cnt), 0);
    @(posedge clk); #1;

    // Error codes: ADR kept, INS kept, unknown code mapped to INS
    for (int k = 0; k < 3; k++) begin
      logic [2:0] sc, es;
      sc = (k == 0) ? 3'd3 : (k == 1) ? 3'd4 : 3'd7;
      es = (k == 0) ? 3'd3 : 3'd4;
      do_reset("err");
      wb_valid = 1; stat_in = sc; icode = 4'h3; dstE = 4'h1; valE = 64'h9;
      @(posedge clk); #1;
      stat_in = 3'd1; srcA = 4'h1;
      @(negedge clk);
      chk($sformatf("err%0d stat", k), 64'(stat), 64'(es));
      chk($sformatf("err%0d halted", k), 64'(halted), 1);
      chk($sformatf("err%0d reg1", k), valA_rd, 0);
      chk($sformatf("err%0d cnt", k), 64'(retire_cnt), 0);
      @(posedge clk); #1;
    end

    // Randomised run against the model
    do_reset("rnd");
    for (int n = 0; n < 3000; n++) begin
      if (!m_run && $urandom_range(0, 7) == 0) do_reset("rnd");
      wb_valid = ($urandom_range(0, 9) != 0);
      icode    = 4'($urandom_range(0, 11));
      cnd      = 1'($urandom);
      stat_in  = ($urandom_range(0, 60) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      dstE     = 4'($urandom);
      dstM     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      valE     = {$urandom, $urandom};
      valM     = {$urandom, $urandom};
      cc_out   = 3'($urandom);
      srcA     = 4'($urandom);
      srcB     = 4'($urandom);
      @(negedge clk);
      chk("rnd valA", valA_rd, exp_rd(srcA));
      chk("rnd valB", valB_rd, exp_rd(srcB));
      chk("rnd cc", 64'(cc_in), 64'(m_cc));
      chk("rnd stat", 64'(stat), 64'(m_stat));
      chk("rnd halted", 64'(halted), 64'(!m_run));
      chk("rnd cnt", 64'(retire_cnt), 64'(m_cnt));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
